// File: rtl/uart_link_arbiter.sv
// rtl/uart_link_arbiter.sv - round-robin arbiter sharing one inter-board UART link between three requesters
//
// Parameters:
//   TIMEOUT_CYCLES  maximum cycles a grant may be held before a forced release (2..65535)
//   GAP_CYCLES      idle cycles with no grant after every release (0 = straight back to IDLE)
//
// Ports:
//   clock_i          system clock, rising edge
//   rst_i            asynchronous active-high reset
//   enable_i         allows new grants when high; sampled only while idle
//   req_i[2:0]       level-sensitive link requests, one bit per bus instance
//   done_i[2:0]      end-of-frame pulses; only the current owner's bit matters
//   grant_o[2:0]     registered one-hot grant, zero while the link is free
//   owner_o[1:0]     index of the current (or most recent) grant holder
//   busy_o           high while a grant or the post-release gap is active
//   timeout_flag_o   one-cycle pulse on the cycle a grant drops due to timeout
//   timeout_count_o  saturating count of timeout releases (only with ARB_STATS_EN)
//
// Build option:
//   ARB_STATS_EN     adds timeout_count_o and its saturating counter

module uart_link_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 2
) (
    input  logic       clock_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [2:0] req_i,
    input  logic [2:0] done_i,
    output logic [2:0] grant_o,
    output logic [1:0] owner_o,
    output logic       busy_o,
`ifdef ARB_STATS_EN
    output logic       timeout_flag_o,
    output logic [7:0] timeout_count_o
`else
    output logic       timeout_flag_o
`endif
);

    // The timer is shared by GRANT and GAP, so it is widened if the gap
    // length would not fit in the timeout-sized counter.
    localparam int TW_TO  = $clog2(TIMEOUT_CYCLES);
    localparam int TW_GAP = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW     = (TW_TO > TW_GAP) ? TW_TO : TW_GAP;

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      grant_q, grant_d;
    logic [1:0]      owner_q, owner_d;
    logic            busy_q, busy_d;
    logic            tflag_q, tflag_d;

    // Search order owner+1, owner+2, owner (mod 3): the last holder always
    // has the lowest priority.
    function automatic logic [1:0] pick_winner(input logic [1:0] last, input logic [2:0] r);
        logic [1:0] n1;
        logic [1:0] n2;
        n1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
        if (r[n1])
            pick_winner = n1;
        else if (r[n2])
            pick_winner = n2;
        else
            pick_winner = last;
    endfunction

    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            grant_q <= 3'b000;
            owner_q <= 2'd2;
            busy_q  <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            tflag_q <= tflag_d;
        end
    end

    always_comb begin
        logic       release_now;
        logic       by_timeout;
        logic [1:0] winner;

        state_d     = state_q;
        timer_d     = timer_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        tflag_d     = 1'b0;
        release_now = 1'b0;
        by_timeout  = 1'b0;
        winner      = pick_winner(owner_q, req_i);

        case (state_q)
            S_IDLE: begin
                if (enable_i && (req_i != 3'b000)) begin
                    grant_d = 3'b001 << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    timer_d = '0;
                    state_d = S_GRANT;
                end
            end

            S_GRANT: begin
                // done beats an abort, and both beat the timeout, so a done
                // landing on the last timeout cycle never raises the flag.
                if (done_i[owner_q]) begin
                    release_now = 1'b1;
                end else if (!req_i[owner_q]) begin
                    release_now = 1'b1;
                end else if (timer_q == TO_LAST) begin
                    release_now = 1'b1;
                    by_timeout  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end

                if (release_now) begin
                    grant_d = 3'b000;
                    timer_d = '0;
                    tflag_d = by_timeout;
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
                busy_d  = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    assign grant_o        = grant_q;
    assign owner_o        = owner_q;
    assign busy_o         = busy_q;
    assign timeout_flag_o = tflag_q;

`ifdef ARB_STATS_EN
    logic [7:0] tcount_q;

    // Counts on the same edge that raises timeout_flag_o.
    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i)
            tcount_q <= 8'h00;
        else if (tflag_d && (tcount_q != 8'hFF))
            tcount_q <= tcount_q + 8'h01;
    end

    assign timeout_count_o = tcount_q;
`endif

endmodule

// File: tb/tb_uart_link_arbiter.sv
// tb/tb_uart_link_arbiter.sv - scoreboard bench for uart_link_arbiter with randomized traffic and a reference model

module tb_uart_link_arbiter;

    localparam int TO  = 16;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] done = 3'b000;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       tflag;
`ifdef ARB_STATS_EN
    logic [7:0] tcount;
`endif

    always #5 clk = ~clk;

    uart_link_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clock_i        (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .req_i          (req),
        .done_i         (done),
        .grant_o        (grant),
        .owner_o        (owner),
        .busy_o         (busy),
`ifdef ARB_STATS_EN
        .timeout_flag_o (tflag),
        .timeout_count_o(tcount)
`else
        .timeout_flag_o (tflag)
`endif
    );

    typedef struct packed {
        logic [2:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
        logic [7:0] c;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: "who holds the link, for how long, and how much gap is left".
    bit m_active   = 0;
    int m_owner    = 2;
    int m_held     = 0;
    int m_gap_left = 0;
    bit m_flag     = 0;
    int m_count    = 0;
    int n_grants   = 0;
    int n_timeouts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_cycle(input logic r, input logic [2:0] rq, input logic [2:0] dn, input logic en);
        m_flag = 0;
        if (r) begin
            m_active = 0; m_owner = 2; m_held = 0; m_gap_left = 0; m_count = 0;
        end else if (m_active) begin
            if (dn[m_owner] || !rq[m_owner] || (m_held == TO - 1)) begin
                m_flag     = !dn[m_owner] && rq[m_owner];
                m_active   = 0;
                m_gap_left = GAP;
                if (m_flag) begin
                    n_timeouts++;
                    if (m_count < 255) m_count++;
                end
            end else begin
                m_held++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (en && rq != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_owner + k) % 3;
                if (rq[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_active = 1;
            m_held   = 0;
            n_grants++;
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, and the
    // model's view of the next rising edge is queued for the monitor.
    task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] dn, input logic en);
        exp_t e;
        @(negedge clk);
        rst = r; req = rq; done = dn; enable = en;
        model_cycle(r, rq, dn, en);
        e.g = m_active ? (3'b001 << m_owner) : 3'b000;
        e.o = 2'(m_owner);
        e.b = m_active || (m_gap_left > 0);
        e.t = m_flag;
        e.c = 8'(m_count);
        exp_q.push_back(e);
    endtask

    function automatic logic [2:0] own_done();
        return m_active ? (3'b001 << m_owner) : 3'b000;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", 32'(grant), 32'(e.g));
                chk("owner", 32'(owner), 32'(e.o));
                chk("busy", 32'(busy), 32'(e.b));
                chk("timeout_flag", 32'(tflag), 32'(e.t));
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
`ifdef ARB_STATS_EN
                chk("timeout_count", 32'(tcount), 32'(e.c));
`endif
            end
        end
    end

    initial begin : stimulus
        logic [2:0] rq;
        logic [2:0] dn;
        logic       en;
        logic       r;
        int         drain;

        // Reset state
        repeat (3) step(1, 3'b000, 3'b000, 0);

        // Round robin with all requesting; done during each grant
        for (int i = 0; i < 24; i++) step(0, 3'b111, own_done(), 1);
        repeat (6) step(0, 3'b000, 3'b000, 1);

        // Timeout with requester 1 holding
        for (int i = 0; i < TO + 6; i++) step(0, 3'b010, 3'b000, 1);
        repeat (4) step(0, 3'b000, 3'b000, 1);

        // done on the last timeout cycle of owner 0 wins over timeout
        step(0, 3'b001, 3'b000, 1);
        for (int i = 0; i < TO + 2; i++)
            step(0, 3'b001, (m_active && m_held == TO - 1) ? 3'b001 : 3'b000, 1);
        repeat (4) step(0, 3'b000, 3'b000, 1);

        // Owner 2 aborts by dropping req while done[1] pulses
        repeat (4) step(0, 3'b100, 3'b000, 1);
        step(0, 3'b011, 3'b010, 1);
        repeat (6) step(0, 3'b011, 3'b000, 1);
        step(0, 3'b011, 3'b001, 1);
        repeat (4) step(0, 3'b000, 3'b000, 1);

        // enable low blocks grants; enable drop mid-grant does not cut it
        repeat (20) step(0, 3'b001, 3'b000, 0);
        step(0, 3'b001, 3'b000, 1);
        repeat (5) step(0, 3'b001, 3'b000, 0);
        step(0, 3'b001, 3'b001, 0);
        repeat (4) step(0, 3'b000, 3'b000, 1);

        // Asynchronous reset while owner 1 holds the link
        repeat (3) step(0, 3'b010, 3'b000, 1);
        step(1, 3'b010, 3'b000, 1);
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_owner", 32'(owner), 32'd2);
        chk("async_rst_busy", 32'(busy), 32'd0);
        step(0, 3'b011, 3'b000, 1);
        repeat (3) step(0, 3'b011, 3'b000, 1);

        // Random traffic
        rq = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            dn = 3'b000;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 11) == 0) dn[b] = 1'b1;
            en = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 599) == 0);
            step(r, rq, dn, en);
        end
        step(0, 3'b000, 3'b000, 1);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        if (n_grants < 10 || n_timeouts < 2)
            chk("stimulus_coverage", 32'(n_grants < 10 || n_timeouts < 2), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
